// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: N_S AXI-Stream sources share one AXI-Stream master.
// A grant is held from the first beat of a packet until its last beat is accepted.
module axis_rr_arbiter #(
  parameter int N_S    = 4,
  parameter int WORD_W = 8,
  parameter int BUS_W  = 32,
  localparam int WORDS_PER_BEAT = BUS_W / WORD_W,
  localparam int KEEP_W         = WORDS_PER_BEAT,
  localparam int GRANT_W        = $clog2(N_S)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_S-1:0]          s_valid,
  output logic [N_S-1:0]          s_ready,
  input  logic [N_S*BUS_W-1:0]    s_data,
  input  logic [N_S*KEEP_W-1:0]   s_keep,
  input  logic [N_S-1:0]          s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [BUS_W-1:0]        m_data,
  output logic [KEEP_W-1:0]       m_keep,
  output logic                    m_last,
  output logic [GRANT_W-1:0]      grant,
  output logic                    busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state;
  logic [GRANT_W-1:0]   last_grant;
  logic [GRANT_W-1:0]   arb_idx;
  logic [GRANT_W-1:0]   cand;
  logic                 arb_found;
  logic [BUS_W-1:0]     data_arr [N_S];
  logic [KEEP_W-1:0]    keep_arr [N_S];

  always_comb begin
    for (int unsigned i = 0; i < N_S; i++) begin
      data_arr[i] = s_data[i*BUS_W +: BUS_W];
      keep_arr[i] = s_keep[i*KEEP_W +: KEEP_W];
    end
  end

  // Search starts just past the previous winner so every requester is reached within N_S turns.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = last_grant;
    cand      = '0;
    for (int unsigned k = 1; k <= N_S; k++) begin
      cand = GRANT_W'((32'(last_grant) + k) % N_S);
      if (!arb_found && s_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_comb begin
    s_ready = '0;
    m_valid = 1'b0;
    m_data  = '0;
    m_keep  = '0;
    m_last  = 1'b0;
    if (state == BUSY) begin
      m_valid        = s_valid[grant];
      m_data         = data_arr[grant];
      m_keep         = keep_arr[grant];
      m_last         = s_last[grant];
      s_ready[grant] = m_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      grant      <= '0;
      last_grant <= GRANT_W'(N_S - 1);
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            grant <= arb_idx;
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (m_valid && m_ready && m_last) begin
            last_grant <= grant;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: per-source packet queues feed the DUT,
// output beats are collected and compared against hand-listed packet orders.
module tb_axis_rr_arbiter;
  localparam int N_S    = 4;
  localparam int BUS_W  = 32;
  localparam int KEEP_W = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_S-1:0]        s_valid, s_ready, s_last;
  logic [N_S*BUS_W-1:0]  s_data;
  logic [N_S*KEEP_W-1:0] s_keep;
  logic                  m_valid, m_ready, m_last;
  logic [BUS_W-1:0]      m_data;
  logic [KEEP_W-1:0]     m_keep;
  logic [1:0]            grant;
  logic                  busy;

  axis_rr_arbiter #(.N_S(N_S), .WORD_W(8), .BUS_W(BUS_W)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       busy;
    logic [1:0] grant;
    logic       mv;
    logic       ml;
    logic [3:0] sr;
  } smp_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  smp_t  trace[$];
  beat_t beats[$];
  int    exp_src[$];
  int    exp_pid[$];

  int plen [N_S][16];
  int npkt [N_S];
  int pidx [N_S];
  int bidx [N_S];
  bit rnd_ready;
  int viol;
  int n_checks;
  int n_pass;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_src();
    for (int i = 0; i < N_S; i++) begin
      npkt[i] = 0; pidx[i] = 0; bidx[i] = 0;
    end
  endtask

  task automatic load(input int s, input int len);
    plen[s][npkt[s]] = len;
    npkt[s]++;
  endtask

  function automatic bit drained();
    bit d = 1'b1;
    for (int i = 0; i < N_S; i++) if (pidx[i] != npkt[i]) d = 1'b0;
    return d;
  endfunction

  task automatic drive();
    for (int i = 0; i < N_S; i++) begin
      if (pidx[i] < npkt[i]) begin
        s_valid[i] = 1'b1;
        s_last[i]  = (bidx[i] == plen[i][pidx[i]] - 1);
        s_data[i*BUS_W +: BUS_W]   = {8'(i), 8'(pidx[i]), 16'(bidx[i])};
        s_keep[i*KEEP_W +: KEEP_W] = s_last[i] ? 4'h3 : 4'hF;
      end else begin
        s_valid[i] = 1'b0;
        s_last[i]  = 1'b0;
        s_data[i*BUS_W +: BUS_W]   = '0;
        s_keep[i*KEEP_W +: KEEP_W] = '0;
      end
    end
    if (rnd_ready) m_ready = ($urandom_range(0, 9) == 0);
  endtask

  // Entered and left at negedge; outputs are sampled 1 time unit before posedge.
  task automatic cycle();
    logic [N_S-1:0] acc;
    smp_t sm;
    beat_t bt;
    drive();
    #4;
    sm.busy = busy; sm.grant = grant; sm.mv = m_valid; sm.ml = m_last; sm.sr = s_ready;
    trace.push_back(sm);
    acc = s_valid & s_ready;
    if (m_valid && m_ready) begin
      bt.d = m_data; bt.k = m_keep; bt.l = m_last;
      beats.push_back(bt);
    end
    if ((|s_ready) && !m_ready) viol++;
    @(posedge clk);
    for (int i = 0; i < N_S; i++) begin
      if (acc[i]) begin
        bidx[i]++;
        if (bidx[i] == plen[i][pidx[i]]) begin
          bidx[i] = 0;
          pidx[i]++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic run_until_done(input int maxc, input string tag);
    int c = 0;
    while (!drained() && c < maxc) begin
      cycle();
      c++;
    end
    cycle();
    cycle();
    chk({tag, " drained"}, 64'(drained()), 64'd1);
  endtask

  task automatic expect_order(input int s, input int p);
    exp_src.push_back(s);
    exp_pid.push_back(p);
  endtask

  task automatic check_packets(input string tag);
    int bp = 0;
    for (int k = 0; k < exp_src.size(); k++) begin
      int s = exp_src[k];
      int p = exp_pid[k];
      int len = plen[s][p];
      bit bad = 1'b0;
      logic [15:0] first = 16'hFFFF;
      for (int b = 0; b < len; b++) begin
        if (bp >= beats.size()) begin
          bad = 1'b1;
        end else begin
          if (b == 0) first = beats[bp].d[31:16];
          if (beats[bp].d !== {8'(s), 8'(p), 16'(b)}) bad = 1'b1;
          if (beats[bp].l !== (b == len - 1)) bad = 1'b1;
          if (beats[bp].k !== ((b == len - 1) ? 4'h3 : 4'hF)) bad = 1'b1;
        end
        bp++;
      end
      chk($sformatf("%s pkt%0d {bad,src,pid}", tag, k),
          64'({bad, first}), 64'({1'b0, 8'(s), 8'(p)}));
    end
    chk({tag, " beat count"}, 64'(beats.size()), 64'(bp));
    exp_src.delete();
    exp_pid.delete();
    beats.delete();
  endtask

  initial begin
    n_checks = 0; n_pass = 0; viol = 0; rnd_ready = 1'b0;
    rst = 1'b1; m_ready = 1'b1;
    s_valid = '0; s_last = '0; s_data = '0; s_keep = '0;
    clear_src();
    for (int i = 0; i < N_S; i++) load(i, 1);

    // Reset with every source requesting
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk($sformatf("rst%0d m_valid", c), 64'(trace[$].mv), 64'd0);
      chk($sformatf("rst%0d s_ready", c), 64'(trace[$].sr), 64'd0);
      chk($sformatf("rst%0d busy", c), 64'(trace[$].busy), 64'd0);
    end
    rst = 1'b0;
    trace.delete(); beats.delete();
    cycle();
    cycle();
    chk("post-rst first grant", 64'(trace[1].grant), 64'd0);
    chk("post-rst busy", 64'(trace[1].busy), 64'd1);
    chk("post-rst bubble m_valid", 64'(trace[0].mv), 64'd0);
    run_until_done(100, "post-rst");
    for (int i = 0; i < N_S; i++) expect_order(i, 0);
    check_packets("post-rst");

    // Contention: all four sources, three packets each
    clear_src();
    load(0, 1); load(0, 4); load(0, 2);
    load(1, 3); load(1, 1); load(1, 5);
    load(2, 2); load(2, 6); load(2, 1);
    load(3, 4); load(3, 2); load(3, 3);
    run_until_done(500, "contention");
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < N_S; i++) expect_order(i, p);
    check_packets("contention");

    // Single source 2, 5 beats
    clear_src();
    load(2, 5);
    trace.delete();
    for (int c = 0; c < 8; c++) cycle();
    chk("single idle busy", 64'(trace[0].busy), 64'd0);
    chk("single idle s_ready", 64'(trace[0].sr), 64'd0);
    chk("single grant", 64'(trace[1].grant), 64'd2);
    chk("single s_ready", 64'(trace[1].sr), 64'b0100);
    chk("single beat4 m_last", 64'(trace[4].ml), 64'd0);
    chk("single beat5 m_last", 64'(trace[5].ml), 64'd1);
    chk("single busy on last", 64'(trace[5].busy), 64'd1);
    chk("single busy after last", 64'(trace[6].busy), 64'd0);
    chk("single grant held idle", 64'(trace[7].grant), 64'd2);
    expect_order(2, 0);
    check_packets("single");

    // Wrap: make source 3 the last winner, then requests on 1 and 3, later 0
    clear_src();
    load(3, 2);
    run_until_done(50, "wrap-prep");
    expect_order(3, 0);
    check_packets("wrap-prep");
    clear_src();
    load(1, 4); load(3, 2);
    trace.delete();
    for (int c = 0; c < 3; c++) cycle();
    chk("wrap first grant", 64'(trace[1].grant), 64'd1);
    load(0, 2);
    run_until_done(100, "wrap");
    // From last_grant=1 the search order is 2,3,0
    expect_order(1, 0); expect_order(3, 0); expect_order(0, 0);
    check_packets("wrap");

    // Backpressure: m_ready high about 10% of cycles
    clear_src();
    load(0, 2); load(0, 3);
    load(1, 1); load(1, 2);
    load(2, 3); load(2, 1);
    load(3, 2); load(3, 2);
    viol = 0;
    rnd_ready = 1'b1;
    run_until_done(3000, "backpressure");
    rnd_ready = 1'b0;
    m_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      expect_order(1, p); expect_order(2, p); expect_order(3, p); expect_order(0, p);
    end
    check_packets("backpressure");
    chk("backpressure ready while stalled", 64'(viol), 64'd0);

    // Reset in the middle of a 10-beat packet from source 1
    clear_src();
    load(1, 10);
    for (int c = 0; c < 20 && bidx[1] != 3; c++) cycle();
    chk("midrst reached beat3", 64'(bidx[1]), 64'd3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    clear_src();
    trace.delete(); beats.delete();
    cycle();
    chk("midrst m_valid", 64'(trace[0].mv), 64'd0);
    chk("midrst s_ready", 64'(trace[0].sr), 64'd0);
    chk("midrst busy", 64'(trace[0].busy), 64'd0);
    chk("midrst grant", 64'(trace[0].grant), 64'd0);
    load(0, 3);
    trace.delete();
    run_until_done(50, "midrst");
    chk("midrst fresh grant", 64'(trace[1].grant), 64'd0);
    expect_order(0, 0);
    check_packets("midrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
